// File: rtl/tft_spi_reader.sv
// tft_spi_reader: SPI mode-0 read-back master for the TFT panel with req/gnt pin sharing; TFT_RD_TIMEOUT_EN adds a grant-wait timeout
module tft_spi_reader #(
  parameter int CLK_DIV = 4,
  parameter int DUMMY_BITS = 1,
  parameter int MAX_BYTES = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             cmd,
  input  logic [2:0]             num_bytes,
  output logic                   bus_req,
  input  logic                   bus_gnt,
  output logic                   tft_sck,
  output logic                   tft_sdi,
  output logic                   tft_cs,
  output logic                   tft_dc,
  input  logic                   tft_sdo,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [8*MAX_BYTES-1:0] rdata
);
  localparam int RW = 8 * MAX_BYTES;
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(8 * MAX_BYTES + 1);
  localparam int NW = $clog2(MAX_BYTES + 1);
  localparam logic [CW-1:0] CD_M1 = CW'(CLK_DIV - 1);
  typedef enum logic [2:0] {IDLE, REQ, CS_SETUP, CMD, DUMMY, READ, CS_HOLD, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [NW-1:0] n_q, n_d;
  logic [7:0] sh_q, sh_d;
  logic [RW-1:0] rdata_q, rdata_d;
  logic sck_q, sck_d, sdi_q, sdi_d, cs_q, cs_d, dc_q, dc_d;
  logic busy_q, busy_d, req_q, req_d, done_q, done_d;
  logic last;
`ifdef TFT_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_M1 = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] to_q, to_d;
  logic err_q, err_d;
  assign err = err_q;
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign err = 1'b0;
`endif
  assign last = cnt_q == CD_M1;
  assign tft_sck = sck_q;
  assign tft_sdi = sdi_q;
  assign tft_cs = cs_q;
  assign tft_dc = dc_q;
  assign busy = busy_q;
  assign bus_req = req_q;
  assign done = done_q;
  assign rdata = rdata_q;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      n_q <= '0;
      sh_q <= '0;
      rdata_q <= '0;
      sck_q <= 1'b0;
      sdi_q <= 1'b0;
      cs_q <= 1'b1;
      dc_q <= 1'b0;
      busy_q <= 1'b0;
      req_q <= 1'b0;
      done_q <= 1'b0;
`ifdef TFT_RD_TIMEOUT_EN
      to_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      n_q <= n_d;
      sh_q <= sh_d;
      rdata_q <= rdata_d;
      sck_q <= sck_d;
      sdi_q <= sdi_d;
      cs_q <= cs_d;
      dc_q <= dc_d;
      busy_q <= busy_d;
      req_q <= req_d;
      done_q <= done_d;
`ifdef TFT_RD_TIMEOUT_EN
      to_q <= to_d;
      err_q <= err_d;
`endif
    end
  always_comb begin
    state_d = state_q;
    cnt_d = last ? '0 : cnt_q + 1'b1;
    bit_d = bit_q;
    n_d = n_q;
    sh_d = sh_q;
    rdata_d = rdata_q;
    sck_d = sck_q;
    sdi_d = sdi_q;
    cs_d = cs_q;
    dc_d = dc_q;
    busy_d = busy_q;
    req_d = req_q;
    done_d = 1'b0;
`ifdef TFT_RD_TIMEOUT_EN
    to_d = '0;
    err_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = REQ;
        busy_d = 1'b1;
        req_d = 1'b1;
        rdata_d = '0;
        sh_d = cmd;
        n_d = ({1'b0, num_bytes} > 4'(MAX_BYTES)) ? NW'(MAX_BYTES) : NW'(num_bytes);
      end
      REQ: begin
`ifdef TFT_RD_TIMEOUT_EN
        to_d = to_q + 1'b1;
        if (to_q == TO_M1) begin
          state_d = IDLE;
          err_d = 1'b1;
          busy_d = 1'b0;
          req_d = 1'b0;
        end
`endif
        if (bus_gnt) begin
          state_d = CS_SETUP;
          cs_d = 1'b0;
          cnt_d = '0;
`ifdef TFT_RD_TIMEOUT_EN
          err_d = 1'b0;
          busy_d = 1'b1;
          req_d = 1'b1;
`endif
        end
      end
      CS_SETUP: if (last) begin
        state_d = CMD;
        sdi_d = sh_q[7];
        sh_d = {sh_q[6:0], 1'b0};
        bit_d = BW'(7);
      end
      CMD, DUMMY, READ: if (last) begin
        sck_d = !sck_q;
        if (!sck_q && state_q == READ) rdata_d = {rdata_q[RW-2:0], tft_sdo};
        if (sck_q) begin
          bit_d = bit_q - 1'b1;
          sdi_d = sh_q[7];
          sh_d = {sh_q[6:0], 1'b0};
          if (bit_q == '0) begin
            dc_d = 1'b1;
            state_d = (state_q == CMD && DUMMY_BITS > 0) ? DUMMY : (state_q != READ && |n_q) ? READ : CS_HOLD;
            bit_d = (state_q == CMD && DUMMY_BITS > 0) ? BW'(DUMMY_BITS - 1) : BW'({n_q - 1'b1, 3'b111});
          end
        end
      end
      CS_HOLD: if (last) begin
        state_d = DONE;
        cs_d = 1'b1;
        dc_d = 1'b0;
        done_d = 1'b1;
        busy_d = 1'b0;
        req_d = 1'b0;
      end
      DONE: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_tft_spi_reader.sv
// tb_tft_spi_reader: directed-vector bench with a mode-0 panel model driving MISO and capturing MOSI
module tb_tft_spi_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic [2:0] num_bytes = 3'd0;
  logic bus_req, bus_gnt = 1'b1;
  logic tft_sck, tft_sdi, tft_cs, tft_dc;
  logic tft_sdo = 1'b0;
  logic busy, done, err;
  logic [31:0] rdata;
  logic [31:0] resp = 32'h0;
  logic [7:0] mosi = 8'h0;
  int k = 0;
  int j;
  int bad_sck = 0;
  int checks = 0;
  int errors = 0;
  tft_spi_reader #(.CLK_DIV(2), .DUMMY_BITS(1), .MAX_BYTES(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .num_bytes(num_bytes),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .tft_sck(tft_sck), .tft_sdi(tft_sdi),
    .tft_cs(tft_cs), .tft_dc(tft_dc), .tft_sdo(tft_sdo), .busy(busy), .done(done),
    .err(err), .rdata(rdata)
  );
  always #5 clk = ~clk;
  always @(negedge tft_cs or posedge tft_sck)
    if (!tft_sck) begin
      k = 0;
      mosi = 8'h0;
    end else if (!tft_cs) begin
      if (!tft_dc) mosi = {mosi[6:0], tft_sdi};
      k++;
    end
  always @(negedge tft_sck) begin
    j = k - 9;
    tft_sdo = (j >= 0 && j < 32) ? resp[31 - j] : 1'b0;
  end
  always @(posedge clk) if (tft_cs && tft_sck) bad_sck++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic txn(input string tag, input logic [7:0] c_in, input logic [2:0] nb, input logic [31:0] r,
                     input int gd, input int exp_cyc, input logic [31:0] exp_rd, input int exp_k);
    int c, bad;
    resp = r;
    cmd = c_in;
    num_bytes = nb;
    bus_gnt = (gd == 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_req"}, bus_req, 1);
    check({tag, "_clr"}, rdata, 32'h0);
    c = 0;
    bad = 0;
    while (c < gd) begin
      if (!bus_req || !busy || !tft_cs || tft_sck) bad++;
      start = (c == 10);
      if (c == 10) cmd = 8'hFF;
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    bus_gnt = 1'b1;
    if (gd > 0) check({tag, "_wait"}, bad, 0);
    while (!done && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    check({tag, "_cyc"}, c, exp_cyc);
    check({tag, "_rdata"}, rdata, exp_rd);
    check({tag, "_edges"}, k, exp_k);
    check({tag, "_mosi"}, mosi, c_in);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_req_end"}, bus_req, 0);
    check({tag, "_cs_end"}, tft_cs, 1);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_hold"}, rdata, exp_rd);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_req", bus_req, 0);
    check("rst_sck", tft_sck, 0);
    check("rst_sdi", tft_sdi, 0);
    check("rst_cs", tft_cs, 1);
    check("rst_dc", tft_dc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 32'h0);
    txn("rddid", 8'h04, 3'd3, 32'h00934100, 0, 137, 32'h00009341, 33);
    txn("cmdonly", 8'h01, 3'd0, 32'hFFFFFFFF, 0, 41, 32'h0, 9);
    txn("clamp", 8'hDA, 3'd7, 32'hDEADBEEF, 0, 169, 32'hDEADBEEF, 41);
`ifndef TFT_RD_TIMEOUT_EN
    txn("gntwait", 8'h0A, 3'd1, 32'h5C000000, 50, 123, 32'h0000005C, 17);
`endif
    resp = 32'hDEADBEEF;
    cmd = 8'h04;
    num_bytes = 3'd4;
    bus_gnt = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_cs", tft_cs, 1);
    check("mid_sck", tft_sck, 0);
    check("mid_busy", busy, 0);
    check("mid_req", bus_req, 0);
    check("mid_rdata", rdata, 32'h0);
    txn("rddst", 8'h09, 3'd2, 32'hA55A0000, 0, 105, 32'h0000A55A, 25);
`ifdef TFT_RD_TIMEOUT_EN
    begin
      int c, nd, ne;
      bus_gnt = 1'b0;
      cmd = 8'h0A;
      num_bytes = 3'd1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      c = 0;
      nd = 0;
      while (!err && c < 200) begin
        @(posedge clk); #1;
        c++;
        nd += int'(done);
      end
      check("to_cyc", c, 16);
      check("to_busy", busy, 0);
      check("to_req", bus_req, 0);
      check("to_rdata", rdata, 32'h0);
      ne = 0;
      repeat (50) begin
        @(posedge clk); #1;
        ne += int'(err);
        nd += int'(done);
        if (!tft_cs) ne++;
      end
      check("to_once", ne, 0);
      check("to_nodone", nd, 0);
      check("to_busy_after", busy, 0);
      bus_gnt = 1'b1;
    end
`endif
    check("sck_low_cs_high", bad_sck, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
